// File: rtl/result_tallier_if.sv
// Handshake and data bundle between the vote logger/consumer side and the
// result tallier; the tallier drives the result fields through the slave modport.
interface result_tallier_if;
  logic       mode;
  logic       start;
  logic [7:0] cand1_vote;
  logic [7:0] cand2_vote;
  logic [7:0] cand3_vote;
  logic [7:0] cand4_vote;
  logic       res_ready;
  logic       busy;
  logic       res_valid;
  logic [1:0] winner;
  logic [7:0] winner_votes;
  logic [9:0] total_votes;
  logic       tie;
  logic       no_votes;
  logic       timeout;

  modport master (
    output mode, start, cand1_vote, cand2_vote, cand3_vote, cand4_vote, res_ready,
    input  busy, res_valid, winner, winner_votes, total_votes, tie, no_votes, timeout
  );

  modport slave (
    input  mode, start, cand1_vote, cand2_vote, cand3_vote, cand4_vote, res_ready,
    output busy, res_valid, winner, winner_votes, total_votes, tie, no_votes, timeout
  );
endinterface

// File: rtl/result_tallier.sv
// Result tallier: snapshots four candidate vote counts, scans them one per cycle
// and presents winner, total and tie/no-vote flags behind a ready/valid handshake.
module result_tallier #(
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  result_tallier_if.slave bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;

  state_t        r_state;
  logic [7:0]    r_shadow [4];
  logic [1:0]    r_idx;
  logic [7:0]    r_runMax;
  logic [1:0]    r_runWin;
  logic          r_runTie;
  logic [9:0]    r_runTotal;
  logic [CW-1:0] r_waitCnt;
  logic          r_busy;
  logic          r_resValid;
  logic          r_timeout;
  logic          r_tie;
  logic          r_noVotes;
  logic [1:0]    r_winner;
  logic [7:0]    r_winnerVotes;
  logic [9:0]    r_totalVotes;

  logic [7:0]    w_cand;
  logic [7:0]    w_max;
  logic [1:0]    w_win;
  logic          w_tie;
  logic [9:0]    w_total;

  // Running maximum only moves on strictly greater, so ties keep the lowest index.
  always_comb begin
    w_cand  = r_shadow[r_idx];
    w_max   = r_runMax;
    w_win   = r_runWin;
    w_tie   = r_runTie;
    w_total = r_runTotal + {2'b00, w_cand};
    if (r_idx == 2'd0) begin
      w_max   = w_cand;
      w_win   = 2'd0;
      w_tie   = 1'b0;
      w_total = {2'b00, w_cand};
    end else if (w_cand > r_runMax) begin
      w_max = w_cand;
      w_win = r_idx;
      w_tie = 1'b0;
    end else if (w_cand == r_runMax) begin
      w_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_shadow      <= '{default: '0};
      r_idx         <= 2'd0;
      r_runMax      <= 8'd0;
      r_runWin      <= 2'd0;
      r_runTie      <= 1'b0;
      r_runTotal    <= 10'd0;
      r_waitCnt     <= '0;
      r_busy        <= 1'b0;
      r_resValid    <= 1'b0;
      r_timeout     <= 1'b0;
      r_tie         <= 1'b0;
      r_noVotes     <= 1'b1;
      r_winner      <= 2'd0;
      r_winnerVotes <= 8'd0;
      r_totalVotes  <= 10'd0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.mode && bus.start) begin
            r_shadow[0] <= bus.cand1_vote;
            r_shadow[1] <= bus.cand2_vote;
            r_shadow[2] <= bus.cand3_vote;
            r_shadow[3] <= bus.cand4_vote;
            r_idx       <= 2'd0;
            r_busy      <= 1'b1;
            r_state     <= SCAN;
          end
        end
        SCAN: begin
          if (!bus.mode) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_runMax   <= w_max;
            r_runWin   <= w_win;
            r_runTie   <= w_tie;
            r_runTotal <= w_total;
            r_idx      <= r_idx + 2'd1;
            // Outputs are committed only here so an aborted scan leaves them untouched.
            if (r_idx == 2'd3) begin
              r_winner      <= w_win;
              r_winnerVotes <= w_max;
              r_totalVotes  <= w_total;
              r_tie         <= w_tie & (w_total != 10'd0);
              r_noVotes     <= (w_total == 10'd0);
              r_resValid    <= 1'b1;
              r_waitCnt     <= '0;
              r_state       <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (!bus.mode || bus.res_ready) begin
            r_resValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else if ((TIMEOUT != 0) && (r_waitCnt == LAST_CNT)) begin
            r_resValid <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.res_valid    = r_resValid;
  assign bus.winner       = r_winner;
  assign bus.winner_votes = r_winnerVotes;
  assign bus.total_votes  = r_totalVotes;
  assign bus.tie          = r_tie;
  assign bus.no_votes     = r_noVotes;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_result_tallier.sv
// Self-checking bench for result_tallier: table-driven and model-driven tallies
// through a scoreboard queue, plus hand-written snapshot, timeout, abort and reset sequences.
module tb_result_tallier;

  localparam int TO = 3;

  typedef struct packed {
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c3;
    logic [7:0] c4;
    logic [1:0] winner;
    logic [7:0] votes;
    logic [9:0] total;
    logic       tie;
    logic       noVotes;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_tallier_if tif ();

  result_tallier #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  int   nCompared   = 0;
  int   nMismatched = 0;
  vec_t expQ[$];
  vec_t lastExp;
  vec_t vecTable[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int w, input int v, input int t, input int ti, input int nv);
    vec_t r;
    r.c1 = 8'(a); r.c2 = 8'(b); r.c3 = 8'(c); r.c4 = 8'(d);
    r.winner = 2'(w); r.votes = 8'(v); r.total = 10'(t);
    r.tie = 1'(ti); r.noVotes = 1'(nv);
    return r;
  endfunction

  // Reference: first index holding the maximum; tie when the maximum occurs more than once.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d);
    int vals[4];
    int best;
    int sum;
    int hits;
    vals = '{int'(a), int'(b), int'(c), int'(d)};
    best = 0;
    sum  = 0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      sum += vals[i];
      if (vals[i] > vals[best]) best = i;
    end
    for (int i = 0; i < 4; i++) if (vals[i] == vals[best]) hits++;
    if (sum == 0) return mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    return mk(vals[0], vals[1], vals[2], vals[3], best, vals[best], sum, (hits > 1) ? 1 : 0, 0);
  endfunction

  task automatic applyStimulus(input vec_t v, input bit push);
    @(posedge clk); #1;
    tif.cand1_vote = v.c1;
    tif.cand2_vote = v.c2;
    tif.cand3_vote = v.c3;
    tif.cand4_vote = v.c4;
    tif.start      = 1'b1;
    if (push) expQ.push_back(v);
    @(posedge clk); #1;
    tif.start = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!tif.res_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic checkResult(input int cycles);
    vec_t e;
    checkOutput("res_valid_seen", 32'(tif.res_valid), 32'd1);
    checkOutput("latency", 32'(cycles), 32'd4);
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL scoreboard: got result, expected none queued");
    end else begin
      e = expQ.pop_front();
      lastExp = e;
      checkOutput("winner", 32'(tif.winner), 32'(e.winner));
      checkOutput("winner_votes", 32'(tif.winner_votes), 32'(e.votes));
      checkOutput("total_votes", 32'(tif.total_votes), 32'(e.total));
      checkOutput("tie", 32'(tif.tie), 32'(e.tie));
      checkOutput("no_votes", 32'(tif.no_votes), 32'(e.noVotes));
      checkOutput("busy_present", 32'(tif.busy), 32'd1);
    end
  endtask

  task automatic checkHandshake();
    @(posedge clk); #1;
    checkOutput("res_valid_after_ready", 32'(tif.res_valid), 32'd0);
    checkOutput("busy_after_ready", 32'(tif.busy), 32'd0);
    checkOutput("total_retained", 32'(tif.total_votes), 32'(lastExp.total));
    checkOutput("winner_retained", 32'(tif.winner), 32'(lastExp.winner));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   validCycles;
    bit   sawValid;
    bit   sawBusy;
    bit   sawTimeout;
    vec_t v;

    tif.mode       = 1'b1;
    tif.start      = 1'b0;
    tif.cand1_vote = 8'd0;
    tif.cand2_vote = 8'd0;
    tif.cand3_vote = 8'd0;
    tif.cand4_vote = 8'd0;
    tif.res_ready  = 1'b1;
    rst            = 1'b0;
    lastExp        = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(tif.busy), 32'd0);
    checkOutput("rst_res_valid", 32'(tif.res_valid), 32'd0);
    checkOutput("rst_timeout", 32'(tif.timeout), 32'd0);
    checkOutput("rst_tie", 32'(tif.tie), 32'd0);
    checkOutput("rst_winner", 32'(tif.winner), 32'd0);
    checkOutput("rst_winner_votes", 32'(tif.winner_votes), 32'd0);
    checkOutput("rst_total", 32'(tif.total_votes), 32'd0);
    checkOutput("rst_no_votes", 32'(tif.no_votes), 32'd1);
    rst = 1'b1;

    vecTable[0] = mk(5, 9, 3, 7, 1, 9, 24, 0, 0);
    vecTable[1] = mk(6, 6, 2, 6, 0, 6, 20, 1, 0);
    vecTable[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecTable[3] = mk(255, 255, 255, 255, 0, 255, 1020, 1, 0);
    vecTable[4] = mk(1, 2, 3, 4, 3, 4, 10, 0, 0);
    vecTable[5] = mk(5, 5, 9, 1, 2, 9, 20, 0, 0);
    vecTable[6] = mk(0, 0, 0, 1, 3, 1, 1, 0, 0);
    vecTable[7] = mk(3, 200, 7, 200, 1, 200, 410, 1, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecTable[i], 1'b1);
      waitResult(cyc);
      checkResult(cyc);
      checkHandshake();
    end

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        v = model(8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)),
                  8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)));
      else
        v = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      applyStimulus(v, 1'b1);
      waitResult(cyc);
      checkResult(cyc);
      checkHandshake();
    end

    // Live inputs and a held start during SCAN/PRESENT must not disturb the snapshot.
    tif.res_ready = 1'b0;
    applyStimulus(mk(5, 9, 3, 7, 1, 9, 24, 0, 0), 1'b1);
    tif.cand1_vote = 8'd200;
    tif.cand2_vote = 8'd200;
    tif.cand3_vote = 8'd200;
    tif.cand4_vote = 8'd200;
    tif.start      = 1'b1;
    waitResult(cyc);
    checkResult(cyc);
    @(posedge clk); #1;
    checkOutput("present_hold_valid", 32'(tif.res_valid), 32'd1);
    checkOutput("present_hold_winner", 32'(tif.winner), 32'd1);
    checkOutput("present_hold_total", 32'(tif.total_votes), 32'd24);
    tif.start     = 1'b0;
    tif.res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("snap_ready_valid", 32'(tif.res_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("no_restart_busy", 32'(tif.busy), 32'd0);

    tif.res_ready = 1'b0;
    applyStimulus(mk(1, 2, 3, 4, 3, 4, 10, 0, 0), 1'b1);
    waitResult(cyc);
    checkResult(cyc);
    validCycles = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!tif.res_valid) break;
      validCycles++;
    end
    checkOutput("timeout_valid_cycles", 32'(validCycles), 32'(TO));
    checkOutput("timeout_pulse", 32'(tif.timeout), 32'd1);
    checkOutput("timeout_busy", 32'(tif.busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("timeout_one_cycle", 32'(tif.timeout), 32'd0);

    // Ready arrives on the very edge the timeout would fire: handshake wins.
    applyStimulus(mk(2, 8, 8, 1, 1, 8, 19, 1, 0), 1'b1);
    waitResult(cyc);
    checkResult(cyc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tif.res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("race_valid", 32'(tif.res_valid), 32'd0);
    checkOutput("race_timeout", 32'(tif.timeout), 32'd0);
    checkOutput("race_busy", 32'(tif.busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("race_timeout_late", 32'(tif.timeout), 32'd0);

    applyStimulus(mk(9, 9, 9, 9, 0, 9, 36, 1, 0), 1'b0);
    @(posedge clk); #1;
    tif.mode = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (tif.res_valid) sawValid = 1'b1;
    end
    checkOutput("abort_valid", 32'(sawValid), 32'd0);
    checkOutput("abort_busy", 32'(tif.busy), 32'd0);
    checkOutput("abort_keep_winner", 32'(tif.winner), 32'd1);
    checkOutput("abort_keep_votes", 32'(tif.winner_votes), 32'd8);
    checkOutput("abort_keep_total", 32'(tif.total_votes), 32'd19);
    checkOutput("abort_keep_tie", 32'(tif.tie), 32'd1);
    tif.mode = 1'b1;

    tif.res_ready = 1'b0;
    applyStimulus(mk(10, 20, 30, 40, 3, 40, 100, 0, 0), 1'b1);
    waitResult(cyc);
    checkResult(cyc);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(tif.res_valid), 32'd0);
    checkOutput("midrst_busy", 32'(tif.busy), 32'd0);
    checkOutput("midrst_total", 32'(tif.total_votes), 32'd0);
    checkOutput("midrst_winner_votes", 32'(tif.winner_votes), 32'd0);
    checkOutput("midrst_no_votes", 32'(tif.no_votes), 32'd1);
    checkOutput("midrst_timeout", 32'(tif.timeout), 32'd0);
    #2 rst = 1'b1;
    sawBusy    = 1'b0;
    sawTimeout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (tif.busy) sawBusy = 1'b1;
      if (tif.timeout) sawTimeout = 1'b1;
    end
    checkOutput("postrst_busy", 32'(sawBusy), 32'd0);
    checkOutput("postrst_timeout", 32'(sawTimeout), 32'd0);

    tif.res_ready = 1'b1;
    applyStimulus(mk(0, 0, 0, 1, 3, 1, 1, 0, 0), 1'b1);
    waitResult(cyc);
    checkResult(cyc);
    checkHandshake();

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/result_tallier.md
RESULT_TALLIER -- requirements
Module: result_tallier

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max PRESENT cycles without res_ready before the result is dropped; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mode, input, 1: 1 = result mode (tally permitted), 0 = voting mode.
REQ-005 SHALL have port start, input, 1: tally request, sampled on clk.
REQ-006 SHALL have ports cand1_vote..cand4_vote, input, 8 each: per-candidate vote counts from the vote logger.
REQ-007 SHALL have port res_ready, input, 1: consumer accepts the presented result.
REQ-008 SHALL have port busy, output, 1: high in SCAN or PRESENT.
REQ-009 SHALL have port res_valid, output, 1: result presented.
REQ-010 SHALL have port winner, output, 2: winning candidate index (0 = cand1 .. 3 = cand4).
REQ-011 SHALL have port winner_votes, output, 8: winner's count.
REQ-012 SHALL have port total_votes, output, 10: sum of all four counts.
REQ-013 SHALL have port tie, output, 1: another candidate equals the maximum.
REQ-014 SHALL have port no_votes, output, 1: total_votes == 0.
REQ-015 SHALL have port timeout, output, 1: one-cycle pulse when a result is dropped by the timeout.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, PRESENT.
REQ-017 SHALL accept start only in IDLE with mode==1; at that edge, snapshot all four counts into shadow registers and go to SCAN.
REQ-018 SHALL ignore start in SCAN and PRESENT, and whenever mode==0.
REQ-019 SHALL, in SCAN, examine one candidate per cycle in index order 0,1,2,3 from the shadow registers only; live input changes during SCAN SHALL NOT affect the result.
REQ-020 SHALL accumulate total_votes as a 10-bit sum (maximum 1020) with no overflow or wrap.
REQ-021 SHALL replace the running maximum only on strictly-greater comparison, so ties resolve to the lowest index.
REQ-022 SHALL set tie when a candidate equals the running maximum, and clear tie when a strictly greater candidate replaces it.
REQ-023 SHALL, when total_votes==0, drive no_votes=1, tie=0, winner=0, winner_votes=0.
REQ-024 SHALL enter PRESENT and assert res_valid exactly 4 cycles after the accepting edge, i.e. on the edge that examines index 3.
REQ-025 SHALL hold res_valid and all result outputs stable in PRESENT until res_ready is sampled high; on that edge go to IDLE with res_valid=0.
REQ-026 SHALL count cycles in PRESENT; on reaching TIMEOUT (when TIMEOUT!=0) without res_ready, go to IDLE, clear res_valid, and pulse timeout for one cycle.
REQ-027 SHALL give res_ready priority over timeout when both occur on the same edge; timeout SHALL NOT pulse in that case.
REQ-028 SHALL abort to IDLE when mode falls to 0 in SCAN or PRESENT; res_valid SHALL be 0 after that edge, and outputs SHALL keep their pre-start values if the abort happens in SCAN.
REQ-029 SHALL retain winner, winner_votes, total_votes, tie and no_votes after the handshake until the next accepted start.
REQ-030 SHALL ignore res_ready outside PRESENT.

Reset
REQ-031 SHALL, while rst==0 and independent of clk, force state IDLE and busy, res_valid, timeout, tie to 0.
REQ-032 SHALL, in the same reset, force winner, winner_votes and total_votes to 0, force no_votes to 1, and clear the shadow registers and timeout counter.
REQ-033 SHALL start its first accepted tally on the first rising edge after rst deasserts at which start==1 and mode==1.
REQ-034 SHALL, when reset is asserted mid-SCAN or mid-PRESENT, drop the in-flight result with no timeout pulse.

Verification
REQ-035 Counts 5,9,3,7, start with mode=1, res_ready=1 -> res_valid 4 cycles later with winner=1, winner_votes=9, total=24, tie=0; IDLE next edge.
REQ-036 Counts 6,6,2,6 -> winner=0, winner_votes=6, tie=1, total=20; counts 0,0,0,0 -> no_votes=1, tie=0, winner=0.
REQ-037 Counts 255 ×4 -> total_votes=1020, winner=0, tie=1.
REQ-038 Count inputs changed mid-SCAN -> result matches the snapshot; start during SCAN or PRESENT -> no restart.
REQ-039 TIMEOUT=3, res_ready=0 -> res_valid for 3 cycles, then timeout pulse and IDLE; ready and timeout on the same edge -> no pulse.
REQ-040 mode 1->0 during SCAN -> IDLE, res_valid stays 0; rst low during PRESENT -> immediate reset values.
